// File: rtl/lsu_port.sv
// lsu_port: single-outstanding load/store responder driving a grant/valid data-memory bus.
// Build macro LSU_MISALIGN_TRAP_EN: trap misaligned halfword/word accesses instead of force-aligning them.
module lsu_port #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_ren,
  input  logic        lsu_wen,
  input  logic [1:0]  lsu_type,
  input  logic        lsu_sign,
  input  logic [31:0] lsu_addr_base,
  input  logic [31:0] lsu_addr_offset,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [1:0] TYPE_BYTE = 2'd0;
  localparam logic [1:0] TYPE_HALF = 2'd1;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_REQ  = 4'b0010,
    S_RESP = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  // Low address bits after force-alignment (word and reserved types are treated alike).
  function automatic logic [1:0] align_low(input logic [1:0] t, input logic [1:0] a);
    case (t)
      TYPE_BYTE: align_low = a;
      TYPE_HALF: align_low = {a[1], 1'b0};
      default:   align_low = 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] t, input logic [1:0] a);
    case (t)
      TYPE_BYTE: is_misaligned = 1'b0;
      TYPE_HALF: is_misaligned = a[0];
      default:   is_misaligned = (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] t, input logic [1:0] a);
    case (t)
      TYPE_BYTE: be_of = 4'b0001 << a;
      TYPE_HALF: be_of = 4'b0011 << {a[1], 1'b0};
      default:   be_of = 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] wdata_of(input logic [1:0] t, input logic [31:0] d);
    case (t)
      TYPE_BYTE: wdata_of = {4{d[7:0]}};
      TYPE_HALF: wdata_of = {2{d[15:0]}};
      default:   wdata_of = d;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [1:0] t, input logic sgn,
                                           input logic [1:0] a, input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {a, 3'b000};
    case (t)
      TYPE_BYTE: load_fmt = {{24{sgn & sh[7]}}, sh[7:0]};
      TYPE_HALF: load_fmt = {{16{sgn & sh[15]}}, sh[15:0]};
      default:   load_fmt = sh;
    endcase
  endfunction

  state_t         state_r;
  state_t         state_nxt_s;
  logic           err_nxt_s;
  logic [CW-1:0]  cnt_r;
  logic [31:0]    eff_addr_s;
  logic [1:0]     low_s;
  logic           req_s;
  logic           trap_s;
  logic [1:0]     type_r;
  logic           sign_r;
  logic [1:0]     lane_r;
  logic [31:0]    mem_addr_r;
  logic           mem_we_r;
  logic [3:0]     mem_be_r;
  logic [31:0]    mem_wdata_r;
  logic [31:0]    lsu_rdata_r;
  logic           lsu_err_r;

  assign eff_addr_s = lsu_addr_base + lsu_addr_offset;
  assign low_s      = align_low(lsu_type, eff_addr_s[1:0]);
  assign req_s      = lsu_wen | lsu_ren;
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_s     = is_misaligned(lsu_type, eff_addr_s[1:0]);
`else
  assign trap_s     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; grant/response take priority over an expiring wait counter.
  always_comb begin
    state_nxt_s = state_r;
    err_nxt_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_s && trap_s) begin
          state_nxt_s = S_DONE;
          err_nxt_s   = 1'b1;
        end else if (req_s) begin
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_nxt_s = S_RESP;
        end else if (cnt_r == CNT_MAX) begin
          state_nxt_s = S_DONE;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_RESP: begin
        if (mem_rvalid) begin
          state_nxt_s = S_DONE;
        end else if (cnt_r == CNT_MAX) begin
          state_nxt_s = S_DONE;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = S_RESP;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Moore outputs decoded straight from the one-hot state register.
  always_comb begin
    mem_req  = (state_r == S_REQ);
    lsu_done = (state_r == S_DONE);
  end

  // Wait counter for REQ and RESP, cleared on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (state_nxt_s != state_r) begin
      cnt_r <= {CW{1'b0}};
    end else if ((state_r == S_REQ || state_r == S_RESP) && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CW'(1'b1);
    end
  end

  // Request capture; bus-side fields stay frozen until the next accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_r      <= 2'b00;
      sign_r      <= 1'b0;
      lane_r      <= 2'b00;
      mem_addr_r  <= 32'h0000_0000;
      mem_we_r    <= 1'b0;
      mem_be_r    <= 4'h0;
      mem_wdata_r <= 32'h0000_0000;
    end else if (state_r == S_IDLE && req_s && !trap_s) begin
      type_r      <= lsu_type;
      sign_r      <= lsu_sign;
      lane_r      <= low_s;
      mem_addr_r  <= {eff_addr_s[31:2], 2'b00};
      mem_we_r    <= lsu_wen;
      mem_be_r    <= be_of(lsu_type, low_s);
      mem_wdata_r <= wdata_of(lsu_type, lsu_wdata);
    end
  end

  // Completion data: loaded on entry to DONE, zero otherwise (writes and errors return 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsu_rdata_r <= 32'h0000_0000;
      lsu_err_r   <= 1'b0;
    end else if (state_nxt_s == S_DONE) begin
      lsu_err_r   <= err_nxt_s;
      lsu_rdata_r <= (state_r == S_RESP && mem_rvalid && !mem_we_r) ?
                     load_fmt(type_r, sign_r, lane_r, mem_rdata) : 32'h0000_0000;
    end else begin
      lsu_err_r   <= 1'b0;
      lsu_rdata_r <= 32'h0000_0000;
    end
  end

  assign lsu_rdata = lsu_rdata_r;
  assign lsu_err   = lsu_err_r;
  assign mem_addr  = mem_addr_r;
  assign mem_we    = mem_we_r;
  assign mem_be    = mem_be_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_lsu_port.sv
// tb_lsu_port: table-driven vectors with a scoreboard queue, a behavioural memory bus,
// and hand-written sequences for back-to-back, timeout and reset corner cases.
module tb_lsu_port;

  logic        clk;
  logic        rst_n;
  logic        lsu_ren, lsu_wen, lsu_sign;
  logic [1:0]  lsu_type;
  logic [31:0] lsu_addr_base, lsu_addr_offset, lsu_wdata;
  logic        lsu_done, lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  lsu_port #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_ren(lsu_ren), .lsu_wen(lsu_wen), .lsu_type(lsu_type), .lsu_sign(lsu_sign),
    .lsu_addr_base(lsu_addr_base), .lsu_addr_offset(lsu_addr_offset), .lsu_wdata(lsu_wdata),
    .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       name;
    logic        ren, wen;
    logic [1:0]  typ;
    logic        sgn;
    logic [31:0] base, off, wdata;
    int          gdly, rdly;
    logic        gnever, rnever;
    logic [31:0] rd;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_rdata;
    logic        e_err;
    int          lat, reqc;
    int          t_req;
  } vec_t;

  vec_t        vecs[$];
  vec_t        exp_q[$];
  int          total = 0, passed = 0;
  int          cyc = 0, done_cnt = 0, n_gnt = 0;
  int          gnt_dly = 0, rv_dly = 0;
  logic        gnt_never = 1'b0, rv_never = 1'b0, addr_mode = 1'b0, force_rv = 1'b0;
  logic [31:0] rd_val = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : cycle_counter
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  function automatic vec_t mkv(input string nm, input logic ren, input logic wen, input logic [1:0] typ,
                               input logic sgn, input logic [31:0] base, input logic [31:0] off,
                               input logic [31:0] wd, input int gd, input int rdl, input logic gn,
                               input logic rn, input logic [31:0] rd, input logic [31:0] ea,
                               input logic ewe, input logic [3:0] ebe, input logic [31:0] ewd,
                               input logic [31:0] erd, input logic eerr, input int lat, input int reqc);
    vec_t v;
    v.name = nm; v.ren = ren; v.wen = wen; v.typ = typ; v.sgn = sgn;
    v.base = base; v.off = off; v.wdata = wd; v.gdly = gd; v.rdly = rdl;
    v.gnever = gn; v.rnever = rn; v.rd = rd; v.e_addr = ea; v.e_we = ewe; v.e_be = ebe;
    v.e_wdata = ewd; v.e_rdata = erd; v.e_err = eerr; v.lat = lat; v.reqc = reqc; v.t_req = 0;
    return v;
  endfunction

  // Memory bus model: grant after gnt_dly request cycles, respond rv_dly cycles after grant.
  initial begin : bus_model
    int  wcnt;
    logic pend;
    wcnt = 0; pend = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst_n || lsu_done) begin
        pend = 1'b0; wcnt = 0;
      end else if (force_rv) begin
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF; force_rv = 1'b0;
      end else if (pend) begin
        if (!rv_never && wcnt == rv_dly) begin
          mem_rvalid = 1'b1;
          mem_rdata = addr_mode ? mem_addr : rd_val;
          pend = 1'b0; wcnt = 0;
        end else wcnt++;
      end else if (mem_req) begin
        if (!gnt_never && wcnt == gnt_dly) begin
          mem_gnt = 1'b1; pend = 1'b1; wcnt = 0; n_gnt++;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // Monitor: captures bus fields at request start, checks stability, scores each completion.
  initial begin : monitor
    logic        in_req;
    int          req_len;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;
    logic [3:0]  cap_be;
    logic        stable;
    vec_t        e;
    in_req = 1'b0; req_len = 0;
    cap_addr = 32'h0; cap_wdata = 32'h0; cap_we = 1'b0; cap_be = 4'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_req = 1'b0;
      end else begin
        if (mem_req) begin
          if (!in_req) begin
            cap_addr = mem_addr; cap_wdata = mem_wdata; cap_we = mem_we; cap_be = mem_be;
            in_req = 1'b1; req_len = 1;
          end else begin
            stable = (mem_addr === cap_addr) && (mem_wdata === cap_wdata) &&
                     (mem_we === cap_we) && (mem_be === cap_be);
            chk("req_stable", 32'(stable), 32'd1);
            req_len++;
          end
        end else begin
          in_req = 1'b0;
        end
        if (lsu_done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_done: got lsu_done=1 rdata=0x%08h, expected no completion", lsu_rdata);
          end else begin
            e = exp_q.pop_front();
            chk({e.name, "/addr"}, cap_addr, e.e_addr);
            chk({e.name, "/we"}, 32'(cap_we), 32'(e.e_we));
            chk({e.name, "/be"}, 32'(cap_be), 32'(e.e_be));
            chk({e.name, "/wdata"}, cap_wdata, e.e_wdata);
            chk({e.name, "/rdata"}, lsu_rdata, e.e_rdata);
            chk({e.name, "/err"}, 32'(lsu_err), 32'(e.e_err));
            chk({e.name, "/latency"}, 32'(cyc - e.t_req), 32'(e.lat));
            chk({e.name, "/req_cycles"}, 32'(req_len), 32'(e.reqc));
          end
        end
      end
    end
  end

  task automatic start_req(input vec_t v);
    vec_t e;
    @(posedge clk); #1;
    gnt_dly = v.gdly; rv_dly = v.rdly; gnt_never = v.gnever; rv_never = v.rnever; rd_val = v.rd;
    lsu_ren = v.ren; lsu_wen = v.wen; lsu_type = v.typ; lsu_sign = v.sgn;
    lsu_addr_base = v.base; lsu_addr_offset = v.off; lsu_wdata = v.wdata;
    e = v;
    e.t_req = cyc;
    exp_q.push_back(e);
    @(posedge clk); #1;
    lsu_ren = 1'b0; lsu_wen = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("done_wait", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic apply(input vec_t v);
    int start;
    start = done_cnt;
    start_req(v);
    wait_done(start + 1, 30);
  endtask

  initial begin : main
    int   base_done, g0, t0, n;
    vec_t e;
    rst_n = 1'b0;
    lsu_ren = 1'b0; lsu_wen = 1'b0; lsu_type = 2'd0; lsu_sign = 1'b0;
    lsu_addr_base = 32'h0; lsu_addr_offset = 32'h0; lsu_wdata = 32'h0;

    //               name           ren   wen   typ   sgn   base          off           wdata         gd rd gn    rn    rd            e_addr        we    be     e_wdata       e_rdata       err  lat rq
    vecs.push_back(mkv("wrd_rd",     1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0000_0008, 32'h0,        0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_1008, 1'b0, 4'hF, 32'h0,        32'hDEAD_BEEF, 1'b0, 3, 1));
    vecs.push_back(mkv("byte_sx",    1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0,        32'h0,        0, 0, 1'b0, 1'b0, 32'h80FF_0000, 32'h0000_1000, 1'b0, 4'h8, 32'h0,        32'hFFFF_FF80, 1'b0, 3, 1));
    vecs.push_back(mkv("byte_zx",    1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0,        32'h0,        0, 0, 1'b0, 1'b0, 32'h80FF_0000, 32'h0000_1000, 1'b0, 4'h8, 32'h0,        32'h0000_0080, 1'b0, 3, 1));
    vecs.push_back(mkv("half_st",    1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_2000, 32'h0000_0002, 32'h0000_1234, 0, 0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_2000, 1'b1, 4'hC, 32'h1234_1234, 32'h0,        1'b0, 3, 1));
    vecs.push_back(mkv("slow_bus",   1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0,        32'h0,        3, 2, 1'b0, 1'b0, 32'h0BAD_F00D, 32'h0000_3000, 1'b0, 4'hF, 32'h0,        32'h0BAD_F00D, 1'b0, 8, 4));
    vecs.push_back(mkv("req_tmo",    1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0,        32'h0,        0, 0, 1'b1, 1'b0, 32'h5555_5555, 32'h0000_4000, 1'b0, 4'hF, 32'h0,        32'h0,        1'b1, 5, 4));
    vecs.push_back(mkv("half_sx",    1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_5000, 32'h0000_0002, 32'h0,        0, 0, 1'b0, 1'b0, 32'h8001_1234, 32'h0000_5000, 1'b0, 4'hC, 32'h0,        32'hFFFF_8001, 1'b0, 3, 1));
    vecs.push_back(mkv("half_misal", 1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_6001, 32'h0,        32'h0,        0, 0, 1'b0, 1'b0, 32'h0000_F00F, 32'h0000_6000, 1'b0, 4'h3, 32'h0,        32'h0000_F00F, 1'b0, 3, 1));
    vecs.push_back(mkv("type3_word", 1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_7003, 32'h0,        32'h0,        0, 0, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_7000, 1'b0, 4'hF, 32'h0,        32'h1234_5678, 1'b0, 3, 1));
    vecs.push_back(mkv("byte_st",    1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_8001, 32'h0,        32'hFFFF_FFA5, 0, 0, 1'b0, 1'b0, 32'h0,        32'h0000_8000, 1'b1, 4'h2, 32'hA5A5_A5A5, 32'h0,        1'b0, 3, 1));
    vecs.push_back(mkv("wen_wins",   1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_9000, 32'h0,        32'hCAFE_BABE, 0, 0, 1'b0, 1'b0, 32'h7777_7777, 32'h0000_9000, 1'b1, 4'hF, 32'hCAFE_BABE, 32'h0,        1'b0, 3, 1));
    vecs.push_back(mkv("addr_wrap",  1'b1, 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0,        0, 0, 1'b0, 1'b0, 32'h1122_3344, 32'h0000_0004, 1'b0, 4'hF, 32'h0,        32'h1122_3344, 1'b0, 3, 1));
    vecs.push_back(mkv("byte_l1",    1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_B000, 32'h0000_0001, 32'h0,        0, 0, 1'b0, 1'b0, 32'h0000_7F00, 32'h0000_B000, 1'b0, 4'h2, 32'h0,        32'h0000_007F, 1'b0, 3, 1));
    vecs.push_back(mkv("resp_tmo",   1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_A000, 32'h0,        32'h0,        3, 0, 1'b0, 1'b1, 32'h0,        32'h0000_A000, 1'b0, 4'hF, 32'h0,        32'h0,        1'b1, 9, 4));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", lsu_rdata, 32'h0);
    chk("rst_ctrl", {24'h0, mem_req, lsu_done, lsu_err, mem_we, mem_be}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Late/spurious response in IDLE must not complete anything.
    base_done = done_cnt;
    @(posedge clk); #1;
    force_rv = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("spurious_rvalid", 32'(done_cnt), 32'(base_done));

    // Back-to-back: ren held, offset advanced on each lsu_done.
    @(posedge clk); #1;
    gnt_dly = 0; rv_dly = 0; gnt_never = 1'b0; rv_never = 1'b0; addr_mode = 1'b1;
    lsu_ren = 1'b1; lsu_wen = 1'b0; lsu_type = 2'd2; lsu_sign = 1'b0;
    lsu_addr_base = 32'h0000_1000; lsu_addr_offset = 32'h0; lsu_wdata = 32'h0;
    t0 = cyc; g0 = n_gnt;
    for (int i = 0; i < 3; i++) begin
      e = mkv("b2b", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0, 32'h0,
              32'h0000_1000 + 32'(4 * i), 1'b0, 4'hF, 32'h0, 32'h0000_1000 + 32'(4 * i), 1'b0, 3, 1);
      e.t_req = t0 + 4 * i;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!lsu_done && n < 20);
      chk("b2b_done_seen", 32'(lsu_done), 32'd1);
      #1;
      lsu_addr_offset = 32'(4 * (i + 1));
      if (i == 2) lsu_ren = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
    chk("b2b_bus_txns", 32'(n_gnt - g0), 32'd3);
    addr_mode = 1'b0;

    // Asynchronous reset while mem_req is high drops it without a clock edge.
    start_req(mkv("rst_req", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_C000, 32'h0, 32'h0, 0, 0, 1'b1, 1'b0,
                  32'h0, 32'h0000_C000, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 3, 1));
    chk("req_before_rst", 32'(mem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_req_mem_req", 32'(mem_req), 32'd0);
    #5 rst_n = 1'b1;
    exp_q.delete();
    base_done = done_cnt;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_in_req_no_done", 32'(done_cnt), 32'(base_done));

    // Asynchronous reset in RESP discards the outstanding response.
    start_req(mkv("rst_resp", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_D000, 32'h0, 32'h0, 0, 0, 1'b0, 1'b1,
                  32'h0, 32'h0000_D000, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 3, 1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_resp_outputs", {29'h0, mem_req, lsu_done, lsu_err}, 32'h0);
    #5 rst_n = 1'b1;
    exp_q.delete();
    base_done = done_cnt;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_in_resp_no_done", 32'(done_cnt), 32'(base_done));

    apply(vecs[0]);
    apply(vecs[3]);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
